// File: rtl/cmp_hit_counter.sv
// Comparator hit sampler: samples both synchronized comparator outputs a fixed
// delay after each reported strobe and accumulates per-channel hit counts.
//   state      | meaning
//   S_IDLE     | waiting for start_i
//   S_WAIT_STB | run active, waiting for the next strobe report
//   S_DELAY    | settling delay after a strobe, down-counting to terminal count
//   S_SAMPLE   | one cycle: count the strobe and comparator hits
//   S_DONE     | one cycle: done_o pulse, counters hold
module cmp_hit_counter #(
  parameter int CNT_WIDTH    = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_DELAY = 2
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] n_stb_i,
  input  logic                 stb_valid_i,
  input  logic                 cmp1_i,
  input  logic                 cmp2_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overrun_o,
  output logic [CNT_WIDTH-1:0] total_o,
  output logic [CNT_WIDTH-1:0] hits1_o,
  output logic [CNT_WIDTH-1:0] hits2_o
);

  localparam int DLY_W = (SAMPLE_DELAY > 1) ? $clog2(SAMPLE_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SAMPLE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_STB,
    S_DELAY,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [CNT_WIDTH-1:0]   n_q, n_d;
  logic [CNT_WIDTH-1:0]   total_q, total_d;
  logic [CNT_WIDTH-1:0]   hits1_q, hits1_d;
  logic [CNT_WIDTH-1:0]   hits2_q, hits2_d;
  logic                   ovr_q, ovr_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync2_q;
  logic                   cmp1_s, cmp2_s;
  logic [CNT_WIDTH-1:0]   total_inc;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], cmp1_i};
      sync2_q <= {sync2_q[SYNC_STAGES-2:0], cmp2_i};
    end
  end

  assign cmp1_s    = sync1_q[SYNC_STAGES-1];
  assign cmp2_s    = sync2_q[SYNC_STAGES-1];
  assign total_inc = total_q + CNT_WIDTH'(1);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      n_q     <= '0;
      total_q <= '0;
      hits1_q <= '0;
      hits2_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      n_q     <= n_d;
      total_q <= total_d;
      hits1_q <= hits1_d;
      hits2_q <= hits2_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    n_d     = n_q;
    total_d = total_q;
    hits1_d = hits1_q;
    hits2_d = hits2_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        // start wins over a coincident abort; abort alone does nothing here
        if (start_i) begin
          total_d = '0;
          hits1_d = '0;
          hits2_d = '0;
          ovr_d   = 1'b0;
          n_d     = n_stb_i;
          state_d = (n_stb_i == '0) ? S_DONE : S_WAIT_STB;
        end
      end
      S_WAIT_STB: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (stb_valid_i) begin
          dly_d   = DLY_LOAD;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (stb_valid_i) ovr_d = 1'b1;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (dly_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      S_SAMPLE: begin
        if (stb_valid_i) ovr_d = 1'b1;
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          total_d = total_inc;
          hits1_d = hits1_q + CNT_WIDTH'(cmp1_s);
          hits2_d = hits2_q + CNT_WIDTH'(cmp2_s);
          state_d = (total_inc == n_q) ? S_DONE : S_WAIT_STB;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q == S_WAIT_STB) || (state_q == S_DELAY) || (state_q == S_SAMPLE);
  assign done_o    = (state_q == S_DONE);
  assign overrun_o = ovr_q;
  assign total_o   = total_q;
  assign hits1_o   = hits1_q;
  assign hits2_o   = hits2_q;

endmodule

// File: tb/tb_cmp_hit_counter.sv
// Bench for cmp_hit_counter: expected run results are queued by the stimulus
// and checked by monitors when done_o pulses; sample latency is also tracked.
module tb_cmp_hit_counter;

  localparam int SD = 2;

  typedef struct packed {
    logic [15:0] tot;
    logic [15:0] h1;
    logic [15:0] h2;
    logic        ovr;
  } exp_t;

  logic        clk;
  logic        arstn;
  logic        start, abort, stb, cmp1, cmp2;
  logic [15:0] n_stb;
  logic        busy, done, ovr;
  logic [15:0] total, hits1, hits2;

  logic        start4, stb4;
  logic [3:0]  n_stb4;
  logic        busy4, done4, ovr4;
  logic [3:0]  total4, hits14, hits24;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done4_cnt = 0;
  logic lat_en = 1'b0;
  logic [15:0] prev_total = '0;
  exp_t exp_q[$];
  exp_t exp4_q[$];
  int   upd_q[$];

  cmp_hit_counter #(.CNT_WIDTH(16), .SYNC_STAGES(2), .SAMPLE_DELAY(SD)) dut (
    .clk_i(clk), .arstn_i(arstn), .start_i(start), .abort_i(abort),
    .n_stb_i(n_stb), .stb_valid_i(stb), .cmp1_i(cmp1), .cmp2_i(cmp2),
    .busy_o(busy), .done_o(done), .overrun_o(ovr),
    .total_o(total), .hits1_o(hits1), .hits2_o(hits2)
  );

  cmp_hit_counter #(.CNT_WIDTH(4), .SYNC_STAGES(2), .SAMPLE_DELAY(SD)) dut4 (
    .clk_i(clk), .arstn_i(arstn), .start_i(start4), .abort_i(1'b0),
    .n_stb_i(n_stb4), .stb_valid_i(stb4), .cmp1_i(cmp1), .cmp2_i(cmp2),
    .busy_o(busy4), .done_o(done4), .overrun_o(ovr4),
    .total_o(total4), .hits1_o(hits14), .hits2_o(hits24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the 16-bit instance, plus sample-latency tracking
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_total", 32'(total), 32'(e.tot));
        chk("done_hits1", 32'(hits1), 32'(e.h1));
        chk("done_hits2", 32'(hits2), 32'(e.h2));
        chk("done_overrun", 32'(ovr), 32'(e.ovr));
      end
    end
    if (lat_en && total != prev_total) begin
      if (upd_q.size() == 0) chk("unexpected_update", 1, 0);
      else chk("update_edge", cyc, upd_q.pop_front());
    end
    prev_total <= total;
  end

  always @(negedge clk) begin
    if (done4) begin
      done4_cnt++;
      if (exp4_q.size() == 0) begin
        chk("unexpected_done4", 1, 0);
      end else begin
        exp_t e;
        e = exp4_q.pop_front();
        chk("done4_total", 32'(total4), 32'(e.tot));
        chk("done4_hits1", 32'(hits14), 32'(e.h1));
        chk("done4_hits2", 32'(hits24), 32'(e.h2));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] n);
    n_stb = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic strobe(input int gap);
    stb = 1'b1;
    if (lat_en) upd_q.push_back(cyc + SD + 2);
    @(negedge clk);
    stb = 1'b0;
    tick(gap - 1);
  endtask

  initial begin
    int d0;
    arstn = 1'b0; start = 0; abort = 0; stb = 0; cmp1 = 0; cmp2 = 0; n_stb = '0;
    start4 = 0; stb4 = 0; n_stb4 = '0;
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(ovr), 0);
    chk("rst_total", 32'(total), 0);
    chk("rst_hits1", 32'(hits1), 0);
    chk("rst_hits2", 32'(hits2), 0);
    arstn = 1'b1;
    tick(2);

    // basic run: n=8, cmp1=1, cmp2=0
    cmp1 = 1; cmp2 = 0;
    tick(4);
    exp_q.push_back('{tot: 16'd8, h1: 16'd8, h2: 16'd0, ovr: 1'b0});
    d0 = done_cnt;
    do_start(16'd8);
    chk("basic_busy_after_start", 32'(busy), 1);
    chk("basic_total_after_start", 32'(total), 0);
    for (int i = 0; i < 8; i++) strobe(10);
    tick(2);
    chk("basic_done_count", done_cnt - d0, 1);
    chk("basic_busy_after_done", 32'(busy), 0);

    // ratio: cmp1 high at exactly 37 of 100 sample points, cmp2 at 50
    exp_q.push_back('{tot: 16'd100, h1: 16'd37, h2: 16'd50, ovr: 1'b0});
    do_start(16'd100);
    tick(1);
    lat_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cmp1 = ((i * 37) % 100) < 37;
      cmp2 = (i < 50);
      strobe(10);
    end
    tick(2);
    lat_en = 1'b0;
    chk("ratio_pending_updates", upd_q.size(), 0);

    // overrun: second strobe one cycle after the first is dropped
    cmp1 = 1; cmp2 = 0;
    tick(4);
    exp_q.push_back('{tot: 16'd4, h1: 16'd4, h2: 16'd0, ovr: 1'b1});
    d0 = done_cnt;
    do_start(16'd4);
    strobe(1);
    strobe(1);
    tick(8);
    chk("ovr_total_after_pair", 32'(total), 1);
    chk("ovr_flag", 32'(ovr), 1);
    for (int i = 0; i < 3; i++) strobe(10);
    tick(2);
    chk("ovr_done_count", done_cnt - d0, 1);
    chk("ovr_held_after_done", 32'(ovr), 1);

    // n=0: immediate done with zero counts, overrun cleared
    exp_q.push_back('{tot: 16'd0, h1: 16'd0, h2: 16'd0, ovr: 1'b0});
    do_start(16'd0);
    chk("n0_done_next_cycle", 32'(done), 1);
    chk("n0_busy", 32'(busy), 0);
    tick(3);

    // abort after 3 samples, then restart with n=2
    d0 = done_cnt;
    do_start(16'd10);
    for (int i = 0; i < 3; i++) strobe(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tick(3);
    chk("abort_total_held", 32'(total), 3);
    chk("abort_hits1_held", 32'(hits1), 3);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_done", done_cnt - d0, 0);
    cmp1 = 0; cmp2 = 1;
    tick(4);
    exp_q.push_back('{tot: 16'd2, h1: 16'd0, h2: 16'd2, ovr: 1'b0});
    do_start(16'd2);
    chk("restart_total_cleared", 32'(total), 0);
    chk("restart_hits1_cleared", 32'(hits1), 0);
    for (int i = 0; i < 2; i++) strobe(10);
    tick(2);
    chk("restart_done_count", done_cnt - d0, 1);

    // start while busy is ignored; latched n stays 3
    cmp1 = 1; cmp2 = 1;
    tick(4);
    exp_q.push_back('{tot: 16'd3, h1: 16'd3, h2: 16'd3, ovr: 1'b0});
    d0 = done_cnt;
    do_start(16'd3);
    strobe(10);
    do_start(16'd1);
    chk("busy_start_total_kept", 32'(total), 1);
    chk("busy_start_busy", 32'(busy), 1);
    tick(2);
    for (int i = 0; i < 2; i++) strobe(10);
    tick(2);
    chk("busy_start_done_count", done_cnt - d0, 1);

    // asynchronous reset mid-run with total=5
    d0 = done_cnt;
    do_start(16'd10);
    for (int i = 0; i < 5; i++) strobe(10);
    chk("midrst_total_before", 32'(total), 5);
    #1 arstn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_total", 32'(total), 0);
    chk("midrst_hits1", 32'(hits1), 0);
    chk("midrst_hits2", 32'(hits2), 0);
    chk("midrst_overrun", 32'(ovr), 0);
    @(negedge clk);
    arstn = 1'b1;
    tick(10);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_busy_after", 32'(busy), 0);

    // 4-bit counters at full scale
    cmp1 = 1; cmp2 = 0;
    tick(4);
    exp4_q.push_back('{tot: 16'd15, h1: 16'd15, h2: 16'd0, ovr: 1'b0});
    n_stb4 = 4'd15; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      stb4 = 1'b1;
      @(negedge clk);
      stb4 = 1'b0;
      tick(3);
    end
    tick(2);
    chk("w4_total", 32'(total4), 15);
    chk("w4_busy", 32'(busy4), 0);
    chk("w4_done_count", done4_cnt, 1);
    chk("w4_overrun", 32'(ovr4), 0);

    chk("exp_queue_empty", exp_q.size(), 0);
    chk("exp4_queue_empty", exp4_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
